ysyx_25040109_imem_resp: RTL and testbench

Instruction-memory responder: the memory side of the fetch handshake whose consumer is the IFU. It accepts one fetch address at a time from the PC source, reads a synchronous single-port SRAM, and can add a configurable plus pseudo-random delay. It then presents the instruction on `imem_rdata`/`mem_valid` and holds it until the IFU asserts `ifu_ready_to_mem`.

---
 rtl/ysyx_25040109_imem_pkg.sv | 16 +
 rtl/ysyx_25040109_lfsr8.sv | 16 +
 rtl/ysyx_25040109_imem_resp.sv | 116 +++++++++++
 tb/tb_ysyx_25040109_imem_resp.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040109_imem_pkg.sv
// Shared types and constants for the instruction-memory responder and its LFSR.
package ysyx_25040109_imem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_WAIT,
    S_RESP
  } imem_state_t;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
  localparam logic [7:0] LFSR_TAPS         = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;

endpackage

// File: rtl/ysyx_25040109_lfsr8.sv
// 8-bit Fibonacci LFSR, advances every non-reset cycle; reusable as a jitter source.
module ysyx_25040109_lfsr8
  import ysyx_25040109_imem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= seed;
    else     q <= {q[6:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/ysyx_25040109_imem_resp.sv
// Instruction-memory responder: one outstanding fetch, SRAM read, optional
// configurable plus LFSR-jittered delay, response held until the IFU accepts.
//
// state  | meaning
// IDLE   | pc_ready high, waiting for a fetch request
// READ   | sram_ren pulse with the aligned address
// CAPT   | capture SRAM data, compute delay
// WAIT   | count down the extra delay
// RESP   | mem_valid high until ifu_ready_to_mem
module ysyx_25040109_imem_resp
  import ysyx_25040109_imem_pkg::*;
#(
  parameter int         ADDR_W     = 32,
  parameter int         DATA_W     = 32,
  parameter int         LAT_W      = 4,
  parameter int         RAND_DELAY = 1,
  parameter logic [7:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_ready,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              mem_valid,
  input  logic              ifu_ready_to_mem,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic [LAT_W-1:0]  cfg_lat
);

  localparam logic [LAT_W:0] CNT_ONE = {{LAT_W{1'b0}}, 1'b1};

  imem_state_t       state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [LAT_W:0]    cnt;
  logic [7:0]        lfsr;
  logic [LAT_W:0]    jitter;
  logic [LAT_W:0]    dly;
  logic              unused_bits;

  ysyx_25040109_lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr)
  );

  // One extra bit so cfg_lat max plus jitter max never wraps.
  assign jitter = (RAND_DELAY != 0) ? {{(LAT_W-1){1'b0}}, lfsr[1:0]} : '0;
  assign dly    = {1'b0, cfg_lat} + jitter;

  assign sram_addr   = addr_q;
  assign imem_rdata  = data_q;
  assign unused_bits = ^{lfsr, pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc_ready  <= 1'b1;
      sram_ren  <= 1'b0;
      mem_valid <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pc_valid) begin
            addr_q   <= {pc[ADDR_W-1:2], 2'b00};
            pc_ready <= 1'b0;
            sram_ren <= 1'b1;
            state    <= S_READ;
          end
        end
        S_READ: begin
          sram_ren <= 1'b0;
          state    <= S_CAPT;
        end
        S_CAPT: begin
          data_q <= sram_rdata;
          if (dly == '0) begin
            mem_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt   <= dly;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            mem_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (ifu_ready_to_mem) begin
            mem_valid <= 1'b0;
            pc_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          pc_ready  <= 1'b1;
          sram_ren  <= 1'b0;
          mem_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_imem_resp.sv
// Bench for the instruction-memory responder: a deterministic instance for directed
// timing checks and a jittered instance checked against an LFSR/latency reference.
module tb_ysyx_25040109_imem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        pc_valid;
  logic [31:0] pc;
  logic        ifu_ready;
  logic [3:0]  cfg_lat;

  logic        pr0, pr1, mv0, mv1, ren0, ren1;
  logic [31:0] rd0, rd1, sa0, sa1, sd0, sd1;

  ysyx_25040109_imem_resp #(.RAND_DELAY(0)) dut0 (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .pc_ready(pr0),
    .imem_rdata(rd0), .mem_valid(mv0), .ifu_ready_to_mem(ifu_ready),
    .sram_ren(ren0), .sram_addr(sa0), .sram_rdata(sd0), .cfg_lat(cfg_lat)
  );

  ysyx_25040109_imem_resp #(.RAND_DELAY(1), .LFSR_SEED(8'hA5)) dut1 (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .pc_ready(pr1),
    .imem_rdata(rd1), .mem_valid(mv1), .ifu_ready_to_mem(ifu_ready),
    .sram_ren(ren1), .sram_addr(sa1), .sram_rdata(sd1), .cfg_lat(cfg_lat)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // SRAM models: data valid the cycle after a read enable, garbage otherwise.
  always @(posedge clk) sd0 <= ren0 ? mem_fn(sa0) : $urandom;
  always @(posedge clk) sd1 <= ren1 ? mem_fn(sa1) : $urandom;

  // Reference LFSR for the jittered instance, polynomial x^8+x^6+x^5+x^4+1.
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  bit sel;
  logic        o_pr, o_mv, o_ren;
  logic [31:0] o_rd, o_sa;
  assign o_pr  = sel ? pr1  : pr0;
  assign o_mv  = sel ? mv1  : mv0;
  assign o_ren = sel ? ren1 : ren0;
  assign o_rd  = sel ? rd1  : rd0;
  assign o_sa  = sel ? sa1  : sa0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pc_valid = 1'b0;
    ifu_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge while idle; returns at the negedge after the handshake.
  task automatic fetch(input logic [31:0] a, input logic [3:0] lat, input int hold_low);
    logic [31:0] aligned, exp_data;
    int exp_dly, n, w;
    aligned  = {a[31:2], 2'b00};
    exp_data = mem_fn(aligned);
    cfg_lat  = lat;
    pc       = a;
    pc_valid = 1'b1;
    ifu_ready = (hold_low == 0);
    w = 0;
    while (!o_pr && w < 50) begin @(negedge clk); w++; end
    chk("accept_ready", o_pr, 1'b1);
    @(negedge clk);
    pc_valid = 1'b0;
    chk("read_ren", o_ren, 1'b1);
    chk("read_addr", o_sa, aligned);
    chk("read_pc_ready", o_pr, 1'b0);
    @(negedge clk);
    chk("capt_ren", o_ren, 1'b0);
    chk("capt_valid", o_mv, 1'b0);
    exp_dly = int'(lat) + (sel ? int'(m_lfsr[1:0]) : 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_mv && n <= 40);
    chk("latency", n + 2, exp_dly + 3);
    for (int i = 1; i <= hold_low + 1; i++) begin
      chk("resp_valid", o_mv, 1'b1);
      chk("resp_data", o_rd, exp_data);
      if (hold_low > 0) chk("resp_pc_ready", o_pr, 1'b0);
      ifu_ready = (i == hold_low + 1);
      @(negedge clk);
    end
    chk("post_valid", o_mv, 1'b0);
    chk("post_pc_ready", o_pr, 1'b1);
  endtask

  task automatic reset_mid(input logic [3:0] lat, input int offset, input logic exp_mv);
    int stale;
    cfg_lat = lat;
    pc = 32'h8000_0040;
    pc_valid = 1'b1;
    ifu_ready = 1'b0;
    chk("rm_accept", o_pr, 1'b1);
    repeat (offset) @(negedge clk);
    pc_valid = 1'b0;
    chk("rm_state_valid", o_mv, exp_mv);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ifu_ready = 1'b1;
    chk("rm_valid", o_mv, 1'b0);
    chk("rm_pc_ready", o_pr, 1'b1);
    chk("rm_ren", o_ren, 1'b0);
    chk("rm_data", o_rd, 32'h0);
    stale = 0;
    repeat (30) begin @(negedge clk); if (o_mv) stale++; end
    chk("rm_stale", stale, 0);
  endtask

  initial begin
    pc = 32'h0;
    cfg_lat = 4'd0;
    sel = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst_pc_ready", o_pr, 1'b1);
    chk("rst_valid", o_mv, 1'b0);
    chk("rst_ren", o_ren, 1'b0);
    chk("rst_addr", o_sa, 32'h0);
    chk("rst_data", o_rd, 32'h0);
    chk("rst_jit_data", rd1, 32'h0);

    fetch(32'h8000_0000, 4'd0, 0);
    fetch(32'h8000_0100, 4'd5, 0);
    fetch(32'h8000_0010, 4'd2, 4);
    fetch(32'h8000_0006, 4'd0, 0);
    fetch(32'h8000_0208, 4'd15, 1);

    reset_mid(4'd5, 5, 1'b0);
    reset_mid(4'd0, 3, 1'b1);

    sel = 1'b1;
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 1000; k++) begin
      fetch($urandom, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
